// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the slave and master-side code.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, followed by one delay
// flop so that rising and falling edges of the synchronized level can be
// detected in the clk domain.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  // Next state: shift the raw input into the chain, remember the last level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and delay flops, preset to the line's idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = ~prev_q &  level;
  assign fall  =  prev_q & ~level;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples sclk/mosi/ss_n with the system clock,
// shifts DATA_W-bit frames MSB first in both directions, and hands received
// bytes to a consumer through a one-entry holding register with overrun and
// framing-error reporting.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
  logic ss_lvl, ss_rise, ss_fall;

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic              tx_load_q, tx_load_d;
  logic              byte_done;
  logic [DATA_W-1:0] rx_byte;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .d     (sclk),
    .level (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .d     (mosi),
    .level (mosi_lvl),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // ss_n idles high, so its chain presets to 1 to avoid a false select edge.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk   (clk),
    .reset (reset),
    .d     (ss_n),
    .level (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // Byte as it will look after the current sclk rise shifts mosi in.
  assign rx_byte = {rx_shift_q[DATA_W-2:0], mosi_lvl};

  // Frame FSM and shifters: sample on sclk rise, advance miso on sclk fall.
  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    tx_load_d   = 1'b0;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          tx_load_d  = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d     = IDLE;
          rx_shift_d  = '0;
          bit_cnt_d   = '0;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          rx_shift_d = rx_byte;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            tx_shift_d = tx_data;
            tx_load_d  = 1'b1;
            byte_done  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall && (bit_cnt_q != '0)) begin
          // A zero count here means a fresh byte was just loaded; its MSB
          // must stay on miso until the master samples it.
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: accept when empty or draining, otherwise flag overrun.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = ovr_clr ? 1'b0 : overrun_q;
    if (byte_done && (!rx_valid_q || rx_ready)) begin
      rx_data_d  = rx_byte;
      rx_valid_d = 1'b1;
    end else begin
      if (byte_done) begin
        overrun_d = 1'b1;
      end
      if (rx_valid_q && rx_ready) begin
        rx_valid_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      tx_load_q   <= tx_load_d;
    end
  end

  assign miso      = ss_lvl ? 1'b0 : tx_shift_q[DATA_W-1];
  assign tx_load   = tx_load_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-bangs a mode-0 master at 50 clk per
// sclk half-period and checks received data, handshakes and status flags.
module tb_spi_slave;

  localparam int unsigned W    = 8;
  localparam int unsigned SS   = 2;
  localparam int unsigned HALF = 50;

  logic         clk = 1'b0;
  logic         reset;
  logic         sclk;
  logic         mosi;
  logic         ss_n;
  logic         miso;
  logic [W-1:0] tx_data;
  logic         tx_load;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         overrun;
  logic         ovr_clr;
  logic         frame_err;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int tx_load_cnt = 0;
  int frame_err_cnt = 0;
  logic [W-1:0] hs_log[$];

  spi_slave #(.SYNC_STAGES(SS), .DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .miso      (miso),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Event monitors sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (tx_load === 1'b1) tx_load_cnt++;
    if (frame_err === 1'b1) frame_err_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) hs_log.push_back(rx_data);
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Shift nbits of m_out MSB first; optionally bound the rx_valid latency
  // after the last rise of a full byte.
  task automatic spi_byte(input logic [W-1:0] m_out, output logic [W-1:0] m_in,
                          input int unsigned nbits, input bit chk_lat);
    int unsigned n;
    logic        seen;
    m_in = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      mosi = m_out[W-1-i];
      tick(HALF);
      sclk = 1'b1;
      m_in[W-1-i] = miso;
      if (chk_lat && i == W - 1) begin
        n    = 0;
        seen = 1'b0;
        for (int unsigned j = 0; j < SS + 2; j++) begin
          tick(1);
          n++;
          if (rx_valid === 1'b1) begin
            seen = 1'b1;
            break;
          end
        end
        check("rx_valid_latency", seen, 1);
        tick(HALF - n);
      end else begin
        tick(HALF);
      end
      sclk = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] m_in;
    int           tl0;
    int           fe0;

    reset    = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    ss_n     = 1'b1;
    tx_data  = '0;
    rx_ready = 1'b0;
    ovr_clr  = 1'b0;
    tick(3);
    check("reset_flags", {miso, tx_load, rx_valid, overrun, frame_err, busy}, 0);
    check("reset_rx_data", rx_data, 0);
    reset = 1'b0;
    tick(5);
    check("idle_busy", busy, 0);

    // Basic byte: receive 0xA5 while sending 0x3C.
    tx_data = 8'h3C;
    tl0 = tx_load_cnt;
    ss_n = 1'b0;
    tick(HALF);
    check("s1_busy", busy, 1);
    spi_byte(8'hA5, m_in, W, 1'b1);
    check("s1_master_rx", m_in, 8'h3C);
    check("s1_rx_data", rx_data, 8'hA5);
    check("s1_rx_valid", rx_valid, 1);
    ss_n = 1'b1;
    tick(HALF);
    check("s1_tx_load_pulses", tx_load_cnt - tl0, 2);
    check("s1_idle_busy", busy, 0);
    check("s1_idle_miso", miso, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("s1_drained", rx_valid, 0);

    // Back-to-back bytes with the consumer always ready.
    hs_log.delete();
    rx_ready = 1'b1;
    ss_n = 1'b0;
    tick(HALF);
    spi_byte(8'h01, m_in, W, 1'b1);
    spi_byte(8'h02, m_in, W, 1'b1);
    ss_n = 1'b1;
    tick(HALF);
    rx_ready = 1'b0;
    check("s2_hs_count", hs_log.size(), 2);
    check("s2_hs0", (hs_log.size() > 0) ? hs_log[0] : 8'hxx, 8'h01);
    check("s2_hs1", (hs_log.size() > 1) ? hs_log[1] : 8'hxx, 8'h02);
    check("s2_overrun", overrun, 0);
    check("s2_rx_valid", rx_valid, 0);

    // Overrun: consumer stalled across two bytes.
    ss_n = 1'b0;
    tick(HALF);
    spi_byte(8'h11, m_in, W, 1'b1);
    spi_byte(8'h22, m_in, W, 1'b0);
    ss_n = 1'b1;
    tick(HALF);
    check("s3_rx_data_kept", rx_data, 8'h11);
    check("s3_rx_valid", rx_valid, 1);
    check("s3_overrun", overrun, 1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check("s3_ovr_clr", overrun, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("s3_drained", rx_valid, 0);

    // Frame error: ss_n released after 3 bits, then a clean frame.
    fe0 = frame_err_cnt;
    ss_n = 1'b0;
    tick(HALF);
    spi_byte(8'hF0, m_in, 3, 1'b0);
    ss_n = 1'b1;
    tick(HALF);
    check("s4_frame_err", frame_err_cnt - fe0, 1);
    check("s4_no_valid", rx_valid, 0);
    ss_n = 1'b0;
    tick(HALF);
    spi_byte(8'h5A, m_in, W, 1'b1);
    ss_n = 1'b1;
    tick(HALF);
    check("s4_rx_data", rx_data, 8'h5A);
    check("s4_frame_err_total", frame_err_cnt - fe0, 1);

    // Reset mid-byte with 0x5A still pending and miso driving ones.
    tx_data = 8'hFF;
    ss_n = 1'b0;
    tick(HALF);
    spi_byte(8'hAA, m_in, 5, 1'b0);
    check("s5_pre_busy", busy, 1);
    check("s5_pre_miso", miso, 1);
    reset = 1'b1;
    #1;
    check("s5_reset_flags", {miso, tx_load, rx_valid, overrun, frame_err, busy}, 0);
    check("s5_reset_rx_data", rx_data, 0);
    ss_n = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(10);
    check("s5_post_busy", busy, 0);
    fe0 = frame_err_cnt;
    tl0 = tx_load_cnt;
    tx_data = 8'h3C;
    ss_n = 1'b0;
    tick(HALF);
    spi_byte(8'hC3, m_in, W, 1'b1);
    ss_n = 1'b1;
    tick(HALF);
    check("s5_rx_data", rx_data, 8'hC3);
    check("s5_master_rx", m_in, 8'h3C);
    check("s5_tx_load_pulses", tx_load_cnt - tl0, 2);
    check("s5_no_frame_err", frame_err_cnt - fe0, 0);

    // Handshake of 0xC3 coincides with completion of 0x96.
    hs_log.delete();
    ss_n = 1'b0;
    tick(HALF);
    spi_byte(8'h96, m_in, W - 1, 1'b0);
    mosi = 1'b0;
    tick(HALF);
    sclk = 1'b1;
    tick(2);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("s6_rx_valid", rx_valid, 1);
    check("s6_rx_data", rx_data, 8'h96);
    check("s6_overrun", overrun, 0);
    check("s6_hs_count", hs_log.size(), 1);
    check("s6_hs0", (hs_log.size() > 0) ? hs_log[0] : 8'hxx, 8'hC3);
    tick(HALF - 3);
    sclk = 1'b0;
    tick(HALF);
    ss_n = 1'b1;
    tick(HALF);
    check("s6_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on each of sclk, mosi and ss_n (minimum 2).
REQ-002 SHALL have parameter DATA_W, default 8, the frame width in bits.
REQ-003 SHALL have port clk, input, 1 bit, system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-005 SHALL have port sclk, input, 1 bit, SPI clock from the master; idles low (mode 0).
REQ-006 SHALL have port mosi, input, 1 bit, serial data from the master, MSB first.
REQ-007 SHALL have port ss_n, input, 1 bit, active-low slave select.
REQ-008 SHALL have port miso, output, 1 bit, serial data to the master, MSB first.
REQ-009 SHALL have port tx_data, input, DATA_W bits, the next byte to transmit.
REQ-010 SHALL have port tx_load, output, 1 bit, a one-cycle pulse when tx_data has been captured into the shifter.
REQ-011 SHALL have port rx_data, output, DATA_W bits, the received byte held in the holding register.
REQ-012 SHALL have port rx_valid, output, 1 bit, asserted while the holding register is unread.
REQ-013 SHALL have port rx_ready, input, 1 bit, consumer accept; a transfer occurs when rx_valid and rx_ready are both high.
REQ-014 SHALL have port overrun, output, 1 bit, sticky flag indicating a byte was dropped.
REQ-015 SHALL have port ovr_clr, input, 1 bit, synchronous clear for overrun.
REQ-016 SHALL have port frame_err, output, 1 bit, a one-cycle pulse when ss_n deasserts mid-byte.
REQ-017 SHALL have port busy, output, 1 bit, high while the FSM is in ACTIVE.

Function
REQ-018 SHALL pass sclk, mosi and ss_n through SYNC_STAGES flops, then one delay flop for edge detection (rise = prev 0 and cur 1; fall = prev 1 and cur 0).
REQ-019 SHALL implement FSM IDLE -> ACTIVE on a synced ss_n falling edge, and ACTIVE -> IDLE on a synced ss_n rising edge; the FSM SHALL ignore sclk edges in IDLE.
REQ-020 On IDLE -> ACTIVE, SHALL load tx_data into tx_shift, clear bit_cnt, and pulse tx_load.
REQ-021 In ACTIVE, on each sclk rise, SHALL shift synced mosi into the LSB of rx_shift and increment bit_cnt.
REQ-022 The rise on which bit_cnt is DATA_W-1 SHALL complete the byte: bit_cnt wraps to 0, tx_shift reloads from tx_data, and tx_load pulses.
REQ-023 In ACTIVE, on sclk fall, SHALL shift tx_shift left by one only when bit_cnt != 0; the fall that follows byte completion SHALL NOT shift.
REQ-024 miso SHALL equal tx_shift[DATA_W-1] combinationally from the register; when ss_n synced is high, miso SHALL be 0.
REQ-025 On byte completion with rx_valid low, or with rx_valid high and rx_ready high in the same cycle, the full byte SHALL be written to rx_data and rx_valid set on the next clk edge.
REQ-026 rx_valid SHALL rise no later than SYNC_STAGES+2 clk cycles after the 8th sclk rise at the pin.
REQ-027 On byte completion with rx_valid high and rx_ready low, SHALL keep the old rx_data, drop the new byte, and set overrun.
REQ-028 rx_valid SHALL clear on a handshake unless a new byte is written in the same cycle.
REQ-029 overrun SHALL clear on ovr_clr; if ovr_clr and a new overrun coincide, overrun SHALL remain set.
REQ-030 On ss_n rise with bit_cnt != 0, SHALL pulse frame_err for one cycle, discard the partial byte, and clear bit_cnt; rx_valid and rx_data SHALL be unaffected.
REQ-031 Multiple bytes within one ss_n-low frame SHALL be supported back-to-back.

Reset
REQ-032 On reset, SHALL force the FSM to IDLE, clear all synchronizers (ss_n sync chain preset to 1), clear tx_shift, rx_shift, rx_data and bit_cnt, and drive rx_valid, overrun, frame_err, tx_load, busy and miso to 0.
REQ-033 Reset asserted mid-byte SHALL discard all state; the first byte after reset SHALL require a fresh ss_n falling edge.

Structure
REQ-034 The state enum (IDLE, ACTIVE) and the DATA_W default SHALL live in the shared package spi_pkg, which spi_master-side code also imports.
REQ-035 The synchronizer plus edge detector SHALL be one reusable sub-module sync_edge, instantiated three times.

Verification
REQ-036 Scenario: master half-period 50 clk, ss_n low, sends 0xA5 while tx_data=0x3C -> rx_data=0xA5, rx_valid within 4 clk of the 8th rise, master receives 0x3C, tx_load pulses twice.
REQ-037 Scenario: one frame carrying 0x01 then 0x02, with rx_ready high -> two rx_valid handshakes in order, overrun remains 0.
REQ-038 Scenario: rx_ready held low, bytes 0x11 then 0x22 -> rx_data stays 0x11, overrun=1; ovr_clr pulse -> overrun=0.
REQ-039 Scenario: ss_n deasserted after 3 bits of 0xF0 -> one frame_err pulse, no rx_valid; the next frame's 0x5A is received correctly.
REQ-040 Scenario: reset asserted after 5 bits -> all outputs 0 within the same cycle; the next full frame 0xC3 is received correctly.
REQ-041 Scenario: a simultaneous handshake and byte completion -> no overrun, new byte present, rx_valid stays high.
